hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core. Drives ID-stage

---
 rtl/hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_ctrl_md_busy_cnt.sv | 41 ++++
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding
// select encodings and small helpers used by the forwarding/stall logic.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // True when a stage that writes 'dest' produces the value a consumer
   // reading 'src' needs. Register $0 is hard-wired, so it never matches.
   function automatic logic dest_hit(input logic       en,
                                     input logic [4:0] dest,
                                     input logic [4:0] src);
      return en && (dest != 5'd0) && (dest == src);
   endfunction

   // EX operand select: the younger MEM result beats the older WB result.
   function automatic logic [1:0] fwd_sel(input logic       reg_write_m,
                                          input logic [4:0] write_reg_m,
                                          input logic       reg_write_w,
                                          input logic [4:0] write_reg_w,
                                          input logic [4:0] src);
      if (dest_hit(reg_write_m, write_reg_m, src)) begin
         return FWD_MEM;
      end else if (dest_hit(reg_write_w, write_reg_w, src)) begin
         return FWD_WB;
      end
      return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// MUL/DIV occupancy counter: a start pulse in EX loads MD_LAT-1, then the
// counter runs down to zero; busy is high while it is non-zero.
module md_busy_cnt
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy
);

   localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LAT - 1);

   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;

   // Next count: load only from idle, otherwise keep running down.
   always_comb begin
      cnt_d = cnt_q;
      if (start && (cnt_q == '0)) begin
         cnt_d = LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Count register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: EX and ID-compare
// forwarding, load-use / branch / MUL-DIV stalls, IF-ID flush on redirect,
// and a saturating count of stalled cycles.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic             BranchD,
   input  logic             JumpRD,
   input  logic             PCSrcD,
   input  logic             MulDivD,
   input  logic             MfHiLoD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic             MulDivE,
   input  logic [4:0]       WriteRegM,
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteW,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MdBusy,
   output logic [CNT_W-1:0] StallCnt
);

   logic lw_stall;
   logic br_stall;
   logic md_stall;
   logic stall;
   logic br_e_hit;
   logic br_m_hit;

   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;

   md_busy_cnt #(
      .MD_LAT (MD_LAT)
   ) u_md_busy_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .start (MulDivE),
      .busy  (MdBusy)
   );

   // Forwarding selects; a load in MEM has no value yet for the ID compare.
   always_comb begin
      ForwardAE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
      ForwardBE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);
      ForwardAD = dest_hit(RegWriteM && !MemtoRegM, WriteRegM, RsD);
      ForwardBD = dest_hit(RegWriteM && !MemtoRegM, WriteRegM, RtD);
   end

   // Stall sources: load-use, ID-resolved branch/jump operands not yet
   // available, and HI/LO access while the MUL/DIV unit is occupied.
   always_comb begin
      lw_stall = dest_hit(MemtoRegE, RtE, RsD) || dest_hit(MemtoRegE, RtE, RtD);
      br_e_hit = dest_hit(RegWriteE, WriteRegE, RsD) ||
                 (BranchD && dest_hit(RegWriteE, WriteRegE, RtD));
      br_m_hit = dest_hit(MemtoRegM, WriteRegM, RsD) ||
                 (BranchD && dest_hit(MemtoRegM, WriteRegM, RtD));
      br_stall = (BranchD || JumpRD) && (br_e_hit || br_m_hit);
      md_stall = (MfHiLoD || MulDivD) && (MdBusy || MulDivE);
      stall    = lw_stall || br_stall || md_stall;
      StallF   = stall;
      StallD   = stall;
      FlushE   = stall;
      FlushD   = PCSrcD && !stall;
   end

   // Saturating stall-cycle counter next value.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Stall-cycle counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle vectors for
// the combinational forwarding/stall logic, then hand-written multi-cycle
// sequences for load-use, branch, MUL/DIV, reset and counter saturation.
module tb_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int CNT_W  = 4;

   typedef struct {
      logic [4:0] rsD, rtD;
      logic       branchD, jumpRD, pcSrcD, mulDivD, mfHiLoD;
      logic [4:0] rsE, rtE, writeRegE;
      logic       regWriteE, memtoRegE, mulDivE;
      logic [4:0] writeRegM;
      logic       regWriteM, memtoRegM;
      logic [4:0] writeRegW;
      logic       regWriteW;
   } stim_t;

   typedef struct {
      logic       stall, flushD, fwdAD, fwdBD;
      logic [1:0] fwdAE, fwdBE;
   } expect_t;

   typedef struct {
      string   name;
      stim_t   s;
      expect_t e;
   } vector_t;

   logic             clk;
   logic             rst_n;
   logic [4:0]       rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
   logic             branchD, jumpRD, pcSrcD, mulDivD, mfHiLoD;
   logic             regWriteE, memtoRegE, mulDivE;
   logic             regWriteM, memtoRegM, regWriteW;
   logic             stallF, stallD, flushD, flushE, fwdAD, fwdBD, mdBusy;
   logic [1:0]       fwdAE, fwdBE;
   logic [CNT_W-1:0] stallCnt;

   int nChecks = 0;
   int nFails  = 0;

   vector_t vec[14];

   hazard_ctrl #(
      .MD_LAT (MD_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RsD       (rsD),
      .RtD       (rtD),
      .BranchD   (branchD),
      .JumpRD    (jumpRD),
      .PCSrcD    (pcSrcD),
      .MulDivD   (mulDivD),
      .MfHiLoD   (mfHiLoD),
      .RsE       (rsE),
      .RtE       (rtE),
      .WriteRegE (writeRegE),
      .RegWriteE (regWriteE),
      .MemtoRegE (memtoRegE),
      .MulDivE   (mulDivE),
      .WriteRegM (writeRegM),
      .RegWriteM (regWriteM),
      .MemtoRegM (memtoRegM),
      .WriteRegW (writeRegW),
      .RegWriteW (regWriteW),
      .StallF    (stallF),
      .StallD    (stallD),
      .FlushD    (flushD),
      .FlushE    (flushE),
      .ForwardAD (fwdAD),
      .ForwardBD (fwdBD),
      .ForwardAE (fwdAE),
      .ForwardBE (fwdBE),
      .MdBusy    (mdBusy),
      .StallCnt  (stallCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic expect_t noHazard();
      expect_t e;
      e = '{default: '0};
      return e;
   endfunction

   task automatic applyStimulus(input stim_t s);
      rsD = s.rsD; rtD = s.rtD;
      branchD = s.branchD; jumpRD = s.jumpRD; pcSrcD = s.pcSrcD;
      mulDivD = s.mulDivD; mfHiLoD = s.mfHiLoD;
      rsE = s.rsE; rtE = s.rtE; writeRegE = s.writeRegE;
      regWriteE = s.regWriteE; memtoRegE = s.memtoRegE; mulDivE = s.mulDivE;
      writeRegM = s.writeRegM; regWriteM = s.regWriteM; memtoRegM = s.memtoRegM;
      writeRegW = s.writeRegW; regWriteW = s.regWriteW;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      nChecks++;
      if (actual !== required) begin
         nFails++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
      end
   endtask

   task automatic checkAll(input string name, input expect_t e);
      checkOutput({name, ".StallF"},    32'(stallF), 32'(e.stall));
      checkOutput({name, ".StallD"},    32'(stallD), 32'(e.stall));
      checkOutput({name, ".FlushE"},    32'(flushE), 32'(e.stall));
      checkOutput({name, ".FlushD"},    32'(flushD), 32'(e.flushD));
      checkOutput({name, ".ForwardAD"}, 32'(fwdAD),  32'(e.fwdAD));
      checkOutput({name, ".ForwardBD"}, 32'(fwdBD),  32'(e.fwdBD));
      checkOutput({name, ".ForwardAE"}, 32'(fwdAE),  32'(e.fwdAE));
      checkOutput({name, ".ForwardBE"}, 32'(fwdBE),  32'(e.fwdBE));
   endtask

   // Drive just after a rising edge, sample on the following falling edge.
   task automatic step(input stim_t s);
      @(posedge clk);
      #1;
      applyStimulus(s);
      @(negedge clk);
   endtask

   task automatic doReset();
      applyStimulus(idle());
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      stim_t   s;
      expect_t e;

      // ---------------- vector table ----------------
      for (int i = 0; i < 14; i++) begin
         vec[i].s = idle();
         vec[i].e = noHazard();
      end
      vec[0].name = "idle";
      vec[1].name = "fwd_mem_prio";
      vec[1].s.regWriteM = 1; vec[1].s.writeRegM = 3;
      vec[1].s.regWriteW = 1; vec[1].s.writeRegW = 3; vec[1].s.rsE = 3;
      vec[1].e.fwdAE = 2'b10;
      vec[2].name = "fwd_wb_kill_m";
      vec[2].s.writeRegM = 3;
      vec[2].s.regWriteW = 1; vec[2].s.writeRegW = 3; vec[2].s.rsE = 3;
      vec[2].e.fwdAE = 2'b01;
      vec[3].name = "fwd_be_wb";
      vec[3].s.rtE = 7; vec[3].s.regWriteW = 1; vec[3].s.writeRegW = 7;
      vec[3].e.fwdBE = 2'b01;
      vec[4].name = "reg0_ignored";
      vec[4].s.regWriteM = 1; vec[4].s.regWriteW = 1;
      vec[5].name = "lwstall_rs";
      vec[5].s.memtoRegE = 1; vec[5].s.regWriteE = 1; vec[5].s.writeRegE = 5;
      vec[5].s.rtE = 5; vec[5].s.rsD = 5; vec[5].s.rtD = 6;
      vec[5].e.stall = 1;
      vec[6].name = "lwstall_rt";
      vec[6].s.memtoRegE = 1; vec[6].s.regWriteE = 1; vec[6].s.writeRegE = 5;
      vec[6].s.rtE = 5; vec[6].s.rsD = 2; vec[6].s.rtD = 5;
      vec[6].e.stall = 1;
      vec[7].name = "fwd_d_taken";
      vec[7].s.regWriteM = 1; vec[7].s.writeRegM = 4; vec[7].s.rsD = 4;
      vec[7].s.rtD = 4; vec[7].s.branchD = 1; vec[7].s.pcSrcD = 1;
      vec[7].e.fwdAD = 1; vec[7].e.fwdBD = 1; vec[7].e.flushD = 1;
      vec[8].name = "br_load_in_m";
      vec[8].s.regWriteM = 1; vec[8].s.memtoRegM = 1; vec[8].s.writeRegM = 4;
      vec[8].s.rsD = 4; vec[8].s.branchD = 1; vec[8].s.pcSrcD = 1;
      vec[8].e.stall = 1;
      vec[9].name = "br_e_rt";
      vec[9].s.branchD = 1; vec[9].s.regWriteE = 1; vec[9].s.writeRegE = 8;
      vec[9].s.rtD = 8; vec[9].s.rsD = 1; vec[9].s.pcSrcD = 1;
      vec[9].e.stall = 1;
      vec[10].name = "jr_ignores_rt";
      vec[10].s.jumpRD = 1; vec[10].s.regWriteE = 1; vec[10].s.writeRegE = 8;
      vec[10].s.rtD = 8; vec[10].s.rsD = 1; vec[10].s.pcSrcD = 1;
      vec[10].e.flushD = 1;
      vec[11].name = "jr_rs_hazard";
      vec[11].s.jumpRD = 1; vec[11].s.regWriteE = 1; vec[11].s.writeRegE = 8;
      vec[11].s.rsD = 8; vec[11].s.pcSrcD = 1;
      vec[11].e.stall = 1;
      vec[12].name = "alu_no_branch";
      vec[12].s.regWriteE = 1; vec[12].s.writeRegE = 8; vec[12].s.rsD = 8;
      vec[13].name = "mdstall_start";
      vec[13].s.mfHiLoD = 1; vec[13].s.mulDivE = 1;
      vec[13].e.stall = 1;

      applyStimulus(idle());
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset.MdBusy",   32'(mdBusy),   32'd0);
      checkOutput("reset.StallCnt", 32'(stallCnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(vec[i].s);
         checkAll(vec[i].name, vec[i].e);
      end
      doReset();

      // ---------------- lw then dependent add ----------------
      s = idle();
      s.memtoRegE = 1; s.regWriteE = 1; s.writeRegE = 5; s.rtE = 5; s.rsD = 5;
      step(s);
      e = noHazard(); e.stall = 1;
      checkAll("lwuse.c1", e);
      s = idle();
      s.regWriteM = 1; s.memtoRegM = 1; s.writeRegM = 5; s.rsD = 5;
      step(s);
      checkAll("lwuse.c2", noHazard());
      s = idle();
      s.rsE = 5; s.regWriteW = 1; s.writeRegW = 5;
      step(s);
      e = noHazard(); e.fwdAE = 2'b01;
      checkAll("lwuse.c3", e);

      // ---------------- beq after add ----------------
      s = idle();
      s.regWriteE = 1; s.writeRegE = 4; s.branchD = 1; s.rsD = 4;
      step(s);
      e = noHazard(); e.stall = 1;
      checkAll("beq_add.c1", e);
      s = idle();
      s.regWriteM = 1; s.writeRegM = 4; s.branchD = 1; s.rsD = 4;
      step(s);
      e = noHazard(); e.fwdAD = 1;
      checkAll("beq_add.c2", e);

      // ---------------- beq after lw: two stall cycles ----------------
      s = idle();
      s.memtoRegE = 1; s.regWriteE = 1; s.writeRegE = 4; s.rtE = 4;
      s.branchD = 1; s.rsD = 4;
      step(s);
      e = noHazard(); e.stall = 1;
      checkAll("beq_lw.c1", e);
      s = idle();
      s.memtoRegM = 1; s.regWriteM = 1; s.writeRegM = 4; s.branchD = 1; s.rsD = 4;
      step(s);
      checkAll("beq_lw.c2", e);
      s = idle();
      s.regWriteW = 1; s.writeRegW = 4; s.branchD = 1; s.rsD = 4;
      step(s);
      checkAll("beq_lw.c3", noHazard());

      // ---------------- MULT in E, MFHI in D ----------------
      doReset();
      s = idle(); s.mulDivE = 1; s.mfHiLoD = 1;
      step(s);
      checkOutput("md.c0.StallD", 32'(stallD), 32'd1);
      checkOutput("md.c0.MdBusy", 32'(mdBusy), 32'd0);
      s = idle(); s.mfHiLoD = 1;
      for (int c = 1; c <= 4; c++) begin
         step(s);
         checkOutput($sformatf("md.c%0d.StallD", c), 32'(stallD), (c < 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("md.c%0d.MdBusy", c), 32'(mdBusy), (c < 4) ? 32'd1 : 32'd0);
      end
      checkOutput("md.StallCnt", 32'(stallCnt), 32'd4);

      // ---------------- reset mid-MUL ----------------
      s = idle(); s.mulDivE = 1;
      step(s);
      step(idle());
      step(idle());
      checkOutput("midmul.busy_before", 32'(mdBusy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midmul.MdBusy",   32'(mdBusy),   32'd0);
      checkOutput("midmul.StallCnt", 32'(stallCnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(idle());
      checkOutput("midmul.after", 32'(mdBusy), 32'd0);

      // ---------------- taken branch with/without stall ----------------
      s = idle(); s.branchD = 1; s.pcSrcD = 1; s.rsD = 9;
      step(s);
      checkOutput("taken.FlushD", 32'(flushD), 32'd1);
      checkOutput("taken.StallD", 32'(stallD), 32'd0);
      s.regWriteE = 1; s.writeRegE = 9;
      step(s);
      checkOutput("taken_st.FlushD", 32'(flushD), 32'd0);
      checkOutput("taken_st.StallD", 32'(stallD), 32'd1);

      // ---------------- StallCnt saturation ----------------
      doReset();
      checkOutput("sat.start", 32'(stallCnt), 32'd0);
      @(posedge clk);
      #1;
      s = idle(); s.memtoRegE = 1; s.rtE = 5; s.rsD = 5;
      applyStimulus(s);
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("sat.cnt5", 32'(stallCnt), 32'd5);
      repeat (15) @(posedge clk);
      @(negedge clk);
      checkOutput("sat.cnt20", 32'(stallCnt), 32'd15);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("sat.hold", 32'(stallCnt), 32'd15);
      applyStimulus(idle());

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
